alu_exec: RTL and testbench

ALU_EXEC -- requirements
Module: alu_exec

---
 rtl/alu_exec_pkg.sv | 68 ++++++
 rtl/alu_exec_if.sv | 31 +++
 rtl/alu_core.sv | 68 ++++++
 rtl/alu_exec.sv | 108 ++++++++++
 tb/tb_alu_exec.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_exec_pkg.sv
// Shared ALU opcode, operation-type and FSM-state definitions for the execute stage.
// Pure definitions: no latency or backpressure of its own.
package alu_exec_pkg;

    localparam int DATA_W = 32;

    localparam logic [5:0] ALU_ADD  = 6'd1;
    localparam logic [5:0] ALU_SUB  = 6'd2;
    localparam logic [5:0] ALU_SLL  = 6'd3;
    localparam logic [5:0] ALU_SRL  = 6'd4;
    localparam logic [5:0] ALU_SRA  = 6'd5;
    localparam logic [5:0] ALU_SLT  = 6'd6;
    localparam logic [5:0] ALU_SLTU = 6'd7;
    localparam logic [5:0] ALU_XOR  = 6'd8;
    localparam logic [5:0] ALU_OR   = 6'd9;
    localparam logic [5:0] ALU_AND  = 6'd10;
    localparam logic [5:0] ALU_LUI  = 6'd11;
    localparam logic [5:0] ALU_JAL  = 6'd12;
    localparam logic [5:0] ALU_JALR = 6'd13;
    localparam logic [5:0] ALU_BEQ  = 6'd14;
    localparam logic [5:0] ALU_BNE  = 6'd15;
    localparam logic [5:0] ALU_BLT  = 6'd16;
    localparam logic [5:0] ALU_BGE  = 6'd17;
    localparam logic [5:0] ALU_BLTU = 6'd18;
    localparam logic [5:0] ALU_BGEU = 6'd19;
    localparam logic [5:0] ALU_LB   = 6'd20;
    localparam logic [5:0] ALU_LH   = 6'd21;
    localparam logic [5:0] ALU_LW   = 6'd22;
    localparam logic [5:0] ALU_LBU  = 6'd23;
    localparam logic [5:0] ALU_LHU  = 6'd24;
    localparam logic [5:0] ALU_SB   = 6'd25;
    localparam logic [5:0] ALU_SH   = 6'd26;
    localparam logic [5:0] ALU_SW   = 6'd27;

    localparam logic [2:0] OP_TYPE_NONE   = 3'd0;
    localparam logic [2:0] OP_TYPE_ARITH  = 3'd1;
    localparam logic [2:0] OP_TYPE_SHIFT  = 3'd2;
    localparam logic [2:0] OP_TYPE_BRANCH = 3'd3;
    localparam logic [2:0] OP_TYPE_JUMP   = 3'd4;
    localparam logic [2:0] OP_TYPE_MEM    = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              br_taken;
        logic [DATA_W-1:0] br_target;
    } alu_res_t;

    function automatic logic [2:0] op_type(input logic [5:0] code);
        case (code)
            ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU,
            ALU_XOR, ALU_OR, ALU_AND, ALU_LUI:      op_type = OP_TYPE_ARITH;
            ALU_SLL, ALU_SRL, ALU_SRA:              op_type = OP_TYPE_SHIFT;
            ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE,
            ALU_BLTU, ALU_BGEU:                     op_type = OP_TYPE_BRANCH;
            ALU_JAL, ALU_JALR:                      op_type = OP_TYPE_JUMP;
            ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU,
            ALU_SB, ALU_SH, ALU_SW:                 op_type = OP_TYPE_MEM;
            default:                                op_type = OP_TYPE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/alu_exec_if.sv
// Operation-in / result-out bundle between operand select, the execute stage and writeback.
// Valid/ready on both sides; flush travels alongside the request.
interface alu_exec_if;
    import alu_exec_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [5:0]        alucode;
    logic [DATA_W-1:0] alu_op1;
    logic [DATA_W-1:0] alu_op2;
    logic [DATA_W-1:0] add_op1;
    logic [DATA_W-1:0] add_op2;
    logic [DATA_W-1:0] pc;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] result;
    logic              br_taken;
    logic [DATA_W-1:0] br_target;

    modport master (
        output in_valid, alucode, alu_op1, alu_op2, add_op1, add_op2, pc, flush, out_ready,
        input  in_ready, out_valid, result, br_taken, br_target
    );

    modport slave (
        input  in_valid, alucode, alu_op1, alu_op2, add_op1, add_op2, pc, flush, out_ready,
        output in_ready, out_valid, result, br_taken, br_target
    );

endinterface

// File: rtl/alu_core.sv
// Single-cycle combinational add/sub/compare/logic/branch-target datapath.
// Zero latency, no state, no backpressure.
module alu_core
    import alu_exec_pkg::*;
(
    input  logic [5:0]        alucode_i,
    input  logic [DATA_W-1:0] alu_op1_i,
    input  logic [DATA_W-1:0] alu_op2_i,
    input  logic [DATA_W-1:0] add_op1_i,
    input  logic [DATA_W-1:0] add_op2_i,
    input  logic [DATA_W-1:0] pc_i,
    output alu_res_t          res_o
);

    logic [DATA_W-1:0] sum;
    logic              cmp_eq;
    logic              cmp_lt_s;
    logic              cmp_lt_u;

    assign sum      = alu_op1_i + alu_op2_i;
    assign cmp_eq   = (add_op1_i == add_op2_i);
    assign cmp_lt_s = ($signed(add_op1_i) < $signed(add_op2_i));
    assign cmp_lt_u = (add_op1_i < add_op2_i);

    always_comb begin
        res_o = '0;
        case (op_type(alucode_i))
            OP_TYPE_MEM: res_o.result = sum;
            OP_TYPE_BRANCH: begin
                res_o.br_target = sum;
                case (alucode_i)
                    ALU_BEQ:  res_o.br_taken = cmp_eq;
                    ALU_BNE:  res_o.br_taken = !cmp_eq;
                    ALU_BLT:  res_o.br_taken = cmp_lt_s;
                    ALU_BGE:  res_o.br_taken = !cmp_lt_s;
                    ALU_BLTU: res_o.br_taken = cmp_lt_u;
                    default:  res_o.br_taken = !cmp_lt_u;
                endcase
            end
            default: begin
                case (alucode_i)
                    ALU_ADD:  res_o.result = sum;
                    ALU_SUB:  res_o.result = alu_op1_i - alu_op2_i;
                    // Shift codes only reach here with a zero shift amount.
                    ALU_SLL, ALU_SRL, ALU_SRA: res_o.result = alu_op1_i;
                    ALU_SLT:  res_o.result = {{(DATA_W-1){1'b0}}, ($signed(alu_op1_i) < $signed(alu_op2_i))};
                    ALU_SLTU: res_o.result = {{(DATA_W-1){1'b0}}, (alu_op1_i < alu_op2_i)};
                    ALU_XOR:  res_o.result = alu_op1_i ^ alu_op2_i;
                    ALU_OR:   res_o.result = alu_op1_i | alu_op2_i;
                    ALU_AND:  res_o.result = alu_op1_i & alu_op2_i;
                    ALU_LUI:  res_o.result = alu_op2_i;
                    ALU_JAL: begin
                        res_o.result    = pc_i + 32'd4;
                        res_o.br_taken  = 1'b1;
                        res_o.br_target = sum;
                    end
                    ALU_JALR: begin
                        res_o.result    = pc_i + 32'd4;
                        res_o.br_taken  = 1'b1;
                        res_o.br_target = {sum[DATA_W-1:1], 1'b0};
                    end
                    default: res_o = '0;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_exec.sv
// Execute stage: latches one op, computes it (shifts iterate one bit per cycle) and holds the result.
// Non-shift ops are valid the cycle after accept, shifts shamt cycles later; results hold until out_ready.
module alu_exec
    import alu_exec_pkg::*;
#(
    parameter int XLEN = DATA_W
) (
    input  logic       clk,
    input  logic       rst,
    alu_exec_if.slave  bus
);

    state_e            state_q, state_d;
    alu_res_t          res_q, res_d;
    alu_res_t          core_res;
    logic [XLEN-1:0]   shreg_q, shreg_d;
    logic [XLEN-1:0]   shstep;
    logic [4:0]        cnt_q, cnt_d;
    logic [5:0]        shcode_q, shcode_d;
    logic [4:0]        shamt;
    logic              accept;

    alu_core u_core (
        .alucode_i (bus.alucode),
        .alu_op1_i (bus.alu_op1),
        .alu_op2_i (bus.alu_op2),
        .add_op1_i (bus.add_op1),
        .add_op2_i (bus.add_op2),
        .pc_i      (bus.pc),
        .res_o     (core_res)
    );

    assign shamt        = bus.alu_op2[4:0];
    assign bus.in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready && !bus.flush;

    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.result    = res_q.result;
    assign bus.br_taken  = res_q.br_taken;
    assign bus.br_target = res_q.br_target;

    always_comb begin
        case (shcode_q)
            ALU_SLL: shstep = {shreg_q[XLEN-2:0], 1'b0};
            ALU_SRA: shstep = {shreg_q[XLEN-1], shreg_q[XLEN-1:1]};
            default: shstep = {1'b0, shreg_q[XLEN-1:1]};
        endcase
    end

    always_comb begin
        state_d  = state_q;
        res_d    = res_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        shcode_d = shcode_q;
        case (state_q)
            ST_SHIFT: begin
                shreg_d = shstep;
                cnt_d   = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d         = ST_DONE;
                    res_d.result    = shstep;
                    res_d.br_taken  = 1'b0;
                    res_d.br_target = '0;
                end
            end
            ST_IDLE, ST_DONE: begin
                if ((state_q == ST_DONE) && bus.out_ready) begin
                    state_d = ST_IDLE;
                end
                if (accept) begin
                    if ((op_type(bus.alucode) == OP_TYPE_SHIFT) && (shamt != 5'd0)) begin
                        state_d  = ST_SHIFT;
                        shreg_d  = bus.alu_op1;
                        cnt_d    = shamt;
                        shcode_d = bus.alucode;
                    end else begin
                        state_d = ST_DONE;
                        res_d   = core_res;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Flush wins over any same-cycle accept or handshake.
        if (bus.flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            res_q    <= '0;
            shreg_q  <= '0;
            cnt_q    <= '0;
            shcode_q <= '0;
        end else begin
            state_q  <= state_d;
            res_q    <= res_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            shcode_q <= shcode_d;
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: scoreboard of model results, compared at each output handshake.
module tb_alu_exec;
    import alu_exec_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    alu_exec_if bus();

    alu_exec #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] result;
        logic        br_taken;
        logic [31:0] br_target;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   n_out  = 0;

    localparam logic [5:0] OPS [29] = '{ALU_ADD, ALU_SUB, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT,
        ALU_SLTU, ALU_XOR, ALU_OR, ALU_AND, ALU_LUI, ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU,
        ALU_SB, ALU_SH, ALU_SW, ALU_JAL, ALU_JALR, ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU,
        ALU_BGEU, 6'd0, 6'd63};

    function automatic exp_t model(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] x, input logic [31:0] y, input logic [31:0] p);
        exp_t e;
        e.result = 32'd0; e.br_taken = 1'b0; e.br_target = 32'd0;
        case (code)
            ALU_ADD, ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU, ALU_SB, ALU_SH, ALU_SW: e.result = a + b;
            ALU_SUB:  e.result = a + ~b + 32'd1;
            ALU_SLL:  e.result = a << b[4:0];
            ALU_SRL:  e.result = a >> b[4:0];
            ALU_SRA:  e.result = $signed(a) >>> b[4:0];
            ALU_SLT:  e.result = {31'd0, ($signed(a) < $signed(b))};
            ALU_SLTU: e.result = {31'd0, (a < b)};
            ALU_XOR:  e.result = a ^ b;
            ALU_OR:   e.result = a | b;
            ALU_AND:  e.result = a & b;
            ALU_LUI:  e.result = b;
            ALU_JAL:  begin e.result = p + 32'd4; e.br_taken = 1'b1; e.br_target = a + b; end
            ALU_JALR: begin e.result = p + 32'd4; e.br_taken = 1'b1; e.br_target = (a + b) & 32'hFFFF_FFFE; end
            ALU_BEQ:  begin e.br_taken = (x == y); e.br_target = a + b; end
            ALU_BNE:  begin e.br_taken = (x != y); e.br_target = a + b; end
            ALU_BLT:  begin e.br_taken = ($signed(x) < $signed(y)); e.br_target = a + b; end
            ALU_BGE:  begin e.br_taken = ($signed(x) >= $signed(y)); e.br_target = a + b; end
            ALU_BLTU: begin e.br_taken = (x < y); e.br_target = a + b; end
            ALU_BGEU: begin e.br_taken = (x >= y); e.br_target = a + b; end
            default:  ;
        endcase
        return e;
    endfunction

    // Output monitor: every handshake pops and compares the oldest expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && bus.out_valid && bus.out_ready && !bus.flush) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: result=%h emitted, required no output", bus.result);
            end else begin
                e = sb.pop_front();
                n_out++;
                if (bus.result !== e.result || bus.br_taken !== e.br_taken || bus.br_target !== e.br_target) begin
                    errors++;
                    $display("FAIL sb_result: got res=%h tk=%b tgt=%h, required res=%h tk=%b tgt=%h",
                             bus.result, bus.br_taken, bus.br_target, e.result, e.br_taken, e.br_target);
                end
            end
        end
    end

    task automatic issue(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] x, input logic [31:0] y, input logic [31:0] p);
        int w;
        bus.in_valid = 1'b1; bus.alucode = code;
        bus.alu_op1 = a; bus.alu_op2 = b; bus.add_op1 = x; bus.add_op2 = y; bus.pc = p;
        w = 0;
        @(negedge clk);
        while (!bus.in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (!bus.in_ready) begin
            errors++;
            $display("FAIL issue_accept: in_ready=%b after %0d cycles, required 1", bus.in_ready, w);
        end else begin
            sb.push_back(model(code, a, b, x, y, p));
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc, output int nrdy);
        cyc = 0; nrdy = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (!bus.in_ready) nrdy++;
        end while (!bus.out_valid && cyc < 100);
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.alucode = '0; bus.alu_op1 = '0; bus.alu_op2 = '0;
        bus.add_op1 = '0; bus.add_op2 = '0; bus.pc = '0; bus.flush = 1'b0; bus.out_ready = 1'b1;
        #1 rst = 1'b1;
        #1;
        checks += 5;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid); end
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready); end
        if (bus.result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h, required 0", bus.result); end
        if (bus.br_taken !== 1'b0) begin errors++; $display("FAIL reset_br_taken: got %b, required 0", bus.br_taken); end
        if (bus.br_target !== 32'd0) begin errors++; $display("FAIL reset_br_target: got %h, required 0", bus.br_target); end
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        int cyc, nr;
        issue(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0);
        wait_valid(cyc, nr);
        checks += 3;
        if (cyc != 1) begin errors++; $display("FAIL add_latency: got %0d cycles, required 1", cyc); end
        if (bus.result !== 32'd0) begin errors++; $display("FAIL add_wrap: got %h, required 0", bus.result); end
        if (bus.br_taken !== 1'b0) begin errors++; $display("FAIL add_br_taken: got %b, required 0", bus.br_taken); end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL add_return_idle: out_valid=%b, required 0", bus.out_valid); end
        drain();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL add_drain: %0d pending, required 0", sb.size()); end
        @(posedge clk); #1;
    endtask

    task automatic test_ops();
        logic [31:0] a, b, x, y, p;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 29; i++) begin
                a = $urandom; b = $urandom; x = $urandom; y = (pass == 1) ? x : $urandom; p = $urandom;
                if (pass == 1) b = $urandom_range(0, 40);
                issue(OPS[i], a, b, x, y, p);
            end
        end
        drain();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL ops_drain: %0d pending, required 0", sb.size()); end
        @(posedge clk); #1;
    endtask

    task automatic test_shift();
        int cyc, nr;
        issue(ALU_SRA, 32'h8000_0000, 32'd31, 32'd0, 32'd0, 32'd0);
        // Offer an ADD throughout the shift; it may only be taken once the result is presented.
        bus.in_valid = 1'b1; bus.alucode = ALU_ADD; bus.alu_op1 = 32'd7; bus.alu_op2 = 32'd9;
        wait_valid(cyc, nr);
        checks += 3;
        if (cyc != 32) begin errors++; $display("FAIL sra31_latency: got %0d cycles, required 32", cyc); end
        if (nr != 31) begin errors++; $display("FAIL sra31_in_ready_low: got %0d cycles, required 31", nr); end
        if (bus.result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sra31_result: got %h, required ffffffff", bus.result); end
        sb.push_back(model(ALU_ADD, 32'd7, 32'd9, 32'd0, 32'd0, 32'd0));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_valid(cyc, nr);
        checks++;
        if (cyc != 1 || bus.result !== 32'd16) begin
            errors++; $display("FAIL shift_then_add: got %0d cycles res=%h, required 1 cycle res=10", cyc, bus.result);
        end
        @(posedge clk); #1;
        issue(ALU_SLL, 32'h5, 32'h0000_0100, 32'd0, 32'd0, 32'd0);
        wait_valid(cyc, nr);
        checks++;
        if (cyc != 1 || bus.result !== 32'h5) begin
            errors++; $display("FAIL sll0: got %0d cycles res=%h, required 1 cycle res=5", cyc, bus.result);
        end
        @(posedge clk); #1;
        issue(ALU_SRL, 32'hF000_0000, 32'd4, 32'd0, 32'd0, 32'd0);
        wait_valid(cyc, nr);
        checks++;
        if (cyc != 5 || bus.result !== 32'h0F00_0000) begin
            errors++; $display("FAIL srl4: got %0d cycles res=%h, required 5 cycles res=0f000000", cyc, bus.result);
        end
        drain();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL shift_drain: %0d pending, required 0", sb.size()); end
        @(posedge clk); #1;
    endtask

    task automatic test_branch();
        int cyc, nr;
        issue(ALU_BLT, 32'h100, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'd1, 32'd0);
        wait_valid(cyc, nr);
        checks++;
        if (bus.br_taken !== 1'b1 || bus.br_target !== 32'hF8 || bus.result !== 32'd0) begin
            errors++; $display("FAIL blt: got tk=%b tgt=%h res=%h, required tk=1 tgt=f8 res=0", bus.br_taken, bus.br_target, bus.result);
        end
        @(posedge clk); #1;
        issue(ALU_BLTU, 32'h100, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'd1, 32'd0);
        wait_valid(cyc, nr);
        checks++;
        if (bus.br_taken !== 1'b0) begin errors++; $display("FAIL bltu: got tk=%b, required 0", bus.br_taken); end
        @(posedge clk); #1;
        issue(ALU_JALR, 32'h1001, 32'd4, 32'd0, 32'd0, 32'h40);
        wait_valid(cyc, nr);
        checks++;
        if (bus.result !== 32'h44 || bus.br_taken !== 1'b1 || bus.br_target !== 32'h1004) begin
            errors++; $display("FAIL jalr: got res=%h tk=%b tgt=%h, required res=44 tk=1 tgt=1004", bus.result, bus.br_taken, bus.br_target);
        end
        drain();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL branch_drain: %0d pending, required 0", sb.size()); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int base;
        base = n_out;
        bus.out_ready = 1'b0;
        fork
            begin
                issue(ALU_ADD, 32'd1, 32'd2, 32'd0, 32'd0, 32'd0);
                issue(ALU_ADD, 32'd100, 32'd200, 32'd0, 32'd0, 32'd0);
                issue(ALU_ADD, 32'hFFFF_0000, 32'h0001_0001, 32'd0, 32'd0, 32'd0);
            end
            begin
                int w;
                w = 0;
                do begin @(negedge clk); w++; end while (!bus.out_valid && w < 20);
                for (int k = 0; k < 3; k++) begin
                    if (k > 0) @(negedge clk);
                    checks++;
                    if (sb.size() == 0 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== sb[0].result) begin
                        errors++;
                        $display("FAIL b2b_hold: cycle %0d vld=%b rdy=%b res=%h, required vld=1 rdy=0 res=00000003",
                                 k, bus.out_valid, bus.in_ready, bus.result);
                    end
                end
                @(posedge clk); #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();
        checks++;
        if (n_out - base != 3 || sb.size() != 0) begin
            errors++; $display("FAIL b2b_count: delivered %0d pending %0d, required 3 and 0", n_out - base, sb.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        int cyc, nr, seen;
        bus.out_ready = 1'b1;
        issue(ALU_SLL, 32'h3, 32'd10, 32'd0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        sb.delete();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_shift: vld=%b rdy=%b, required vld=0 rdy=1", bus.out_valid, bus.in_ready);
        end
        seen = 0;
        repeat (15) begin @(negedge clk); if (bus.out_valid) seen++; end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL flush_no_emit: %0d valid cycles, required 0", seen); end
        @(posedge clk); #1;
        issue(ALU_ADD, 32'd40, 32'd2, 32'd0, 32'd0, 32'd0);
        wait_valid(cyc, nr);
        checks++;
        if (cyc != 1 || bus.result !== 32'd42) begin
            errors++; $display("FAIL flush_recover: %0d cycles res=%h, required 1 cycle res=2a", cyc, bus.result);
        end
        drain();
        @(posedge clk); #1;

        bus.out_ready = 1'b0;
        issue(ALU_ADD, 32'd5, 32'd6, 32'd0, 32'd0, 32'd0);
        wait_valid(cyc, nr);
        sb.delete();
        @(posedge clk); #1;
        bus.flush = 1'b1; bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.alucode = ALU_XOR;
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_over_accept: vld=%b, required 0", bus.out_valid); end

        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        issue(ALU_OR, 32'hF0, 32'h0F, 32'd0, 32'd0, 32'd0);
        wait_valid(cyc, nr);
        sb.delete();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.result !== 32'd0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid_done: vld=%b res=%h rdy=%b, required vld=0 res=0 rdy=1", bus.out_valid, bus.result, bus.in_ready);
        end
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        bus.out_ready = 1'b1;
        seen = 0;
        repeat (5) begin @(negedge clk); if (bus.out_valid) seen++; end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL rst_no_emit: %0d valid cycles, required 0", seen); end
        @(posedge clk); #1;
        issue(ALU_AND, 32'hFF00, 32'h0FF0, 32'd0, 32'd0, 32'd0);
        wait_valid(cyc, nr);
        checks++;
        if (cyc != 1 || bus.result !== 32'h0F00) begin
            errors++; $display("FAIL rst_recover: %0d cycles res=%h, required 1 cycle res=f00", cyc, bus.result);
        end
        drain();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL flush_drain: %0d pending, required 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_ops();
        test_shift();
        test_branch();
        test_back_to_back();
        test_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
